// File: rtl/canvas_pkg.sv
// Shared canvas types: coordinate/attribute widths, the point record used by the
// frame buffer draw ports and the packet unpacker, and the interpolator state enum.
package canvas_pkg;

  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int COLOR_W = 4;
  localparam int SW_W    = 3;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] color;
    logic [SW_W-1:0]    sw;
  } canvas_pt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STEP
  } stroke_interp_state_t;

endpackage

// File: rtl/stroke_interp.sv
// Bresenham line interpolator: fills the pixels between the previous stroke
// endpoint and each new one, emitting one pixel per valid/ready handshake.
module stroke_interp
  import canvas_pkg::*;
#(
  parameter int MAX_JUMP = 64
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               pt_valid_in,
  output logic               pt_ready_out,
  input  logic [X_W-1:0]     x_in,
  input  logic [Y_W-1:0]     y_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic [SW_W-1:0]    sw_in,
  input  logic               flush_in,
  output logic               px_valid_out,
  input  logic               px_ready_in,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [COLOR_W-1:0] color_out,
  output logic [SW_W-1:0]    sw_out
);

  localparam int CW = 12;
  localparam logic signed [CW-1:0] MAX_JUMP_S = CW'(MAX_JUMP);

  stroke_interp_state_t state_reg, state_next;
  logic                 have_prev_reg, have_prev_next;
  logic [X_W-1:0]       prev_x_reg, prev_x_next;
  logic [Y_W-1:0]       prev_y_reg, prev_y_next;
  canvas_pt_t           tgt_reg, tgt_next;
  canvas_pt_t           pix_reg, pix_next;
  logic                 px_valid_reg, px_valid_next;
  logic signed [CW-1:0] dx_reg, dx_next;
  logic signed [CW-1:0] dy_reg, dy_next;
  logic signed [CW-1:0] err_reg, err_next;
  logic                 xneg_reg, xneg_next;
  logic                 yneg_reg, yneg_next;
  logic                 ready_en_reg;

  // Line parameters from prev to target, valid while in SETUP
  logic signed [CW-1:0] diff_x, diff_y, abs_dx, abs_dy;
  assign diff_x = $signed({{(CW-X_W){1'b0}}, tgt_reg.x}) - $signed({{(CW-X_W){1'b0}}, prev_x_reg});
  assign diff_y = $signed({{(CW-Y_W){1'b0}}, tgt_reg.y}) - $signed({{(CW-Y_W){1'b0}}, prev_y_reg});
  assign abs_dx = diff_x[CW-1] ? -diff_x : diff_x;
  assign abs_dy = diff_y[CW-1] ? -diff_y : diff_y;

  // One shared stepper: seeded from prev in SETUP, from the output pixel in STEP
  logic [X_W-1:0]       st_x, step_x;
  logic [Y_W-1:0]       st_y, step_y;
  logic signed [CW-1:0] st_err, st_dx, st_dy, step_err;
  logic                 st_xneg, st_yneg;
  logic signed [CW:0]   e2, dx_ext, dy_ext;

  always_comb begin
    st_x    = pix_reg.x;
    st_y    = pix_reg.y;
    st_err  = err_reg;
    st_dx   = dx_reg;
    st_dy   = dy_reg;
    st_xneg = xneg_reg;
    st_yneg = yneg_reg;
    if (state_reg == ST_SETUP) begin
      st_x    = prev_x_reg;
      st_y    = prev_y_reg;
      st_err  = abs_dx - abs_dy;
      st_dx   = abs_dx;
      st_dy   = -abs_dy;
      st_xneg = diff_x[CW-1];
      st_yneg = diff_y[CW-1];
    end
  end

  assign e2     = $signed({st_err, 1'b0});
  assign dx_ext = $signed({st_dx[CW-1], st_dx});
  assign dy_ext = $signed({st_dy[CW-1], st_dy});

  always_comb begin
    step_err = st_err;
    step_x   = st_x;
    step_y   = st_y;
    if (e2 >= dy_ext) begin
      step_err = step_err + st_dy;
      step_x   = st_xneg ? st_x - X_W'(1) : st_x + X_W'(1);
    end
    if (e2 <= dx_ext) begin
      step_err = step_err + st_dx;
      step_y   = st_yneg ? st_y - Y_W'(1) : st_y + Y_W'(1);
    end
  end

  assign pt_ready_out = ready_en_reg && (state_reg == ST_IDLE) && !flush_in;

  always_comb begin
    state_next     = state_reg;
    have_prev_next = have_prev_reg;
    prev_x_next    = prev_x_reg;
    prev_y_next    = prev_y_reg;
    tgt_next       = tgt_reg;
    pix_next       = pix_reg;
    px_valid_next  = px_valid_reg;
    dx_next        = dx_reg;
    dy_next        = dy_reg;
    err_next       = err_reg;
    xneg_next      = xneg_reg;
    yneg_next      = yneg_reg;

    case (state_reg)
      ST_IDLE: begin
        if (pt_valid_in && pt_ready_out) begin
          tgt_next   = '{x: x_in, y: y_in, color: color_in, sw: sw_in};
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        dx_next   = abs_dx;
        dy_next   = -abs_dy;
        xneg_next = diff_x[CW-1];
        yneg_next = diff_y[CW-1];
        if (!have_prev_reg || abs_dx > MAX_JUMP_S || abs_dy > MAX_JUMP_S) begin
          // Pen jump: the endpoint alone, which ends the line on its handshake
          pix_next      = tgt_reg;
          px_valid_next = 1'b1;
          state_next    = ST_STEP;
        end else if (diff_x == '0 && diff_y == '0) begin
          state_next = ST_IDLE;
        end else begin
          pix_next      = '{x: step_x, y: step_y, color: tgt_reg.color, sw: tgt_reg.sw};
          err_next      = step_err;
          px_valid_next = 1'b1;
          state_next    = ST_STEP;
        end
      end
      ST_STEP: begin
        if (px_valid_reg && px_ready_in) begin
          if (pix_reg.x == tgt_reg.x && pix_reg.y == tgt_reg.y) begin
            px_valid_next  = 1'b0;
            have_prev_next = 1'b1;
            prev_x_next    = tgt_reg.x;
            prev_y_next    = tgt_reg.y;
            state_next     = ST_IDLE;
          end else begin
            pix_next = '{x: step_x, y: step_y, color: tgt_reg.color, sw: tgt_reg.sw};
            err_next = step_err;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (flush_in) begin
      state_next     = ST_IDLE;
      px_valid_next  = 1'b0;
      have_prev_next = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg     <= ST_IDLE;
      have_prev_reg <= 1'b0;
      prev_x_reg    <= '0;
      prev_y_reg    <= '0;
      tgt_reg       <= '0;
      pix_reg       <= '0;
      px_valid_reg  <= 1'b0;
      dx_reg        <= '0;
      dy_reg        <= '0;
      err_reg       <= '0;
      xneg_reg      <= 1'b0;
      yneg_reg      <= 1'b0;
      ready_en_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      have_prev_reg <= have_prev_next;
      prev_x_reg    <= prev_x_next;
      prev_y_reg    <= prev_y_next;
      tgt_reg       <= tgt_next;
      pix_reg       <= pix_next;
      px_valid_reg  <= px_valid_next;
      dx_reg        <= dx_next;
      dy_reg        <= dy_next;
      err_reg       <= err_next;
      xneg_reg      <= xneg_next;
      yneg_reg      <= yneg_next;
      ready_en_reg  <= 1'b1;
    end
  end

  assign px_valid_out = px_valid_reg;
  assign x_out        = pix_reg.x;
  assign y_out        = pix_reg.y;
  assign color_out    = pix_reg.color;
  assign sw_out       = pix_reg.sw;

endmodule
